// File: rtl/if_id_reg.sv
// IF/ID pipeline register: captures fetch PC/instruction/exception, handles stall, flush,
// exception entry and branch-delay-slot tracking. Optional perf counters under IF_ID_PERF_EN.
module if_id_reg #(
  parameter logic [31:0] RESET_PC   = 32'h0000_3000,
  parameter logic [31:0] HANDLER_PC = 32'h0000_4180
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req,
  input  logic        stall,
  input  logic        flush,
  input  logic [31:0] F_pc,
  input  logic [31:0] F_instr,
  input  logic [4:0]  F_exc,
  output logic [31:0] D_pc,
  output logic [31:0] D_instr,
  output logic [4:0]  D_exc,
  output logic        D_bd,
  output logic        D_valid
`ifdef IF_ID_PERF_EN
  ,
  output logic [31:0] stall_cnt,
  output logic [31:0] bubble_cnt
`endif
);

  localparam int unsigned PC_W    = 32;
  localparam int unsigned INSTR_W = 32;
  localparam int unsigned EXC_W   = 5;
  localparam int unsigned OP_W    = 6;

  localparam logic [OP_W-1:0] OP_SPECIAL = 6'b000000;
  localparam logic [OP_W-1:0] OP_REGIMM  = 6'b000001;
  localparam logic [OP_W-1:0] OP_J       = 6'b000010;
  localparam logic [OP_W-1:0] OP_JAL     = 6'b000011;
  localparam logic [OP_W-1:0] OP_BEQ     = 6'b000100;
  localparam logic [OP_W-1:0] OP_BNE     = 6'b000101;
  localparam logic [OP_W-1:0] OP_BLEZ    = 6'b000110;
  localparam logic [OP_W-1:0] OP_BGTZ    = 6'b000111;
  localparam logic [OP_W-1:0] FN_JR      = 6'b001000;
  localparam logic [OP_W-1:0] FN_JALR    = 6'b001001;

  logic [OP_W-1:0]    d_op;
  logic [OP_W-1:0]    d_funct;
  logic               d_is_jump_c;
  logic               jump_now_c;

  logic [PC_W-1:0]    pc_nxt;
  logic [INSTR_W-1:0] instr_nxt;
  logic [EXC_W-1:0]   exc_nxt;
  logic               bd_nxt;
  logic               valid_nxt;

  assign d_op    = D_instr[31:26];
  assign d_funct = D_instr[5:0];

  // Classify the instruction currently in ID as a control transfer with a delay slot.
  always_comb begin
    d_is_jump_c = 1'b0;
    unique case (d_op)
      OP_REGIMM, OP_J, OP_JAL,
      OP_BEQ, OP_BNE, OP_BLEZ, OP_BGTZ: d_is_jump_c = 1'b1;
      OP_SPECIAL: d_is_jump_c = (d_funct == FN_JR) || (d_funct == FN_JALR);
      default:    d_is_jump_c = 1'b0;
    endcase
  end

  // A bubble in ID never turns its successor into a delay slot.
  assign jump_now_c = D_valid & d_is_jump_c;

  // Next-state selection with priority rst > req > stall > flush > load.
  always_comb begin
    pc_nxt    = D_pc;
    instr_nxt = D_instr;
    exc_nxt   = D_exc;
    bd_nxt    = D_bd;
    valid_nxt = D_valid;
    if (rst) begin
      pc_nxt    = RESET_PC;
      instr_nxt = '0;
      exc_nxt   = '0;
      bd_nxt    = 1'b0;
      valid_nxt = 1'b0;
    end else if (req) begin
      pc_nxt    = HANDLER_PC;
      instr_nxt = '0;
      exc_nxt   = '0;
      bd_nxt    = 1'b0;
      valid_nxt = 1'b0;
    end else if (stall) begin
      pc_nxt    = D_pc;
      instr_nxt = D_instr;
      exc_nxt   = D_exc;
      bd_nxt    = D_bd;
      valid_nxt = D_valid;
    end else if (flush) begin
      pc_nxt    = F_pc;
      instr_nxt = '0;
      exc_nxt   = '0;
      bd_nxt    = 1'b0;
      valid_nxt = 1'b0;
    end else begin
      pc_nxt    = F_pc;
      instr_nxt = F_instr;
      exc_nxt   = F_exc;
      bd_nxt    = jump_now_c;
      valid_nxt = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    D_pc    <= pc_nxt;
    D_instr <= instr_nxt;
    D_exc   <= exc_nxt;
    D_bd    <= bd_nxt;
    D_valid <= valid_nxt;
  end

`ifdef IF_ID_PERF_EN
  localparam int unsigned CNT_W = 32;

  logic stall_evt_c;
  logic bubble_evt_c;

  // A stall overridden by req is not a stall; a flush hidden by a stall inserts no bubble.
  assign stall_evt_c  = stall & ~req;
  assign bubble_evt_c = (req | flush) & (~stall | req);

  always_ff @(posedge clk) begin
    if (rst) begin
      stall_cnt  <= '0;
      bubble_cnt <= '0;
    end else begin
      if (stall_evt_c)  stall_cnt  <= stall_cnt + CNT_W'(1);
      if (bubble_evt_c) bubble_cnt <= bubble_cnt + CNT_W'(1);
    end
  end
`endif

endmodule
